// File: rtl/vball_vram_arbiter_if.sv
// Bus bundle for the VRAM arbiter: CPU requester, tile-fetcher requester and RAM port.
// The master side is the system (requesters and RAM); the slave side is the arbiter.
interface vball_vram_arbiter_if #(
    parameter int AW = 13,
    parameter int DW = 8
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic          cpu_ack;
    logic [DW-1:0] cpu_dout;

    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_valid;
    logic [DW-1:0] vid_dout;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        output vid_req, vid_addr,
        output ram_dout,
        input  cpu_ack, cpu_dout, vid_valid, vid_dout,
        input  ram_addr, ram_we, ram_din
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        input  vid_req, vid_addr,
        input  ram_dout,
        output cpu_ack, cpu_dout, vid_valid, vid_dout,
        output ram_addr, ram_we, ram_din
    );
endinterface

// File: rtl/vball_vram_arbiter.sv
// Shares one single-port synchronous VRAM between the CPU and the background tile fetcher.
// Optional CPU starvation guard: define VBALL_VRAM_GUARD_EN.
module vball_vram_arbiter #(
    parameter int AW = 13,
    parameter int DW = 8
`ifdef VBALL_VRAM_GUARD_EN
    ,
    parameter int MAX_WAIT = 6
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_hb,
    input  logic                 i_vb,
    vball_vram_arbiter_if.slave  bus
);

    // Owner tag travelling down the pipeline; also encodes "slot empty" and read/write.
    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_CPU_RD = 2'd1,
        OWN_CPU_WR = 2'd2,
        OWN_VID    = 2'd3
    } owner_e;

    owner_e        w_grant;
    owner_e        r_s1_own;
    owner_e        r_s2_own;

    logic          w_display;
    logic          w_cpu_elig;
    logic          w_vid_elig;
    logic          w_cpu_force;
    logic          w_cpu_grant;
    logic          w_vid_grant;

    logic          r_cpu_busy;
    logic          r_vid_busy;

    logic [AW-1:0] r_ram_addr;
    logic          r_ram_we;
    logic [DW-1:0] r_ram_din;

    logic          r_cpu_ack;
    logic          r_vid_valid;
    logic [DW-1:0] r_cpu_dout;
    logic [DW-1:0] r_vid_dout;

    assign w_display  = !i_hb && !i_vb;
    assign w_cpu_elig = bus.cpu_req && !r_cpu_busy;
    assign w_vid_elig = bus.vid_req && !r_vid_busy;

`ifdef VBALL_VRAM_GUARD_EN
    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    logic [3:0] r_wait_cnt;

    assign w_cpu_force = (r_wait_cnt >= WAIT_LIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (!bus.cpu_req || w_cpu_grant) begin
            r_wait_cnt <= '0;
        end else if (w_cpu_elig && (r_wait_cnt != 4'hF)) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end
`else
    assign w_cpu_force = 1'b0;
`endif

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_grant = OWN_NONE;
        if (w_cpu_elig && (w_cpu_force || !w_display || !w_vid_elig)) begin
            w_grant = bus.cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
        end else if (w_vid_elig) begin
            w_grant = OWN_VID;
        end
    end

    assign w_cpu_grant = (w_grant == OWN_CPU_RD) || (w_grant == OWN_CPU_WR);
    assign w_vid_grant = (w_grant == OWN_VID);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_own    <= OWN_NONE;
            r_s2_own    <= OWN_NONE;
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_din   <= '0;
            r_cpu_ack   <= 1'b0;
            r_vid_valid <= 1'b0;
            r_cpu_dout  <= '0;
            r_vid_dout  <= '0;
        end else begin
            r_s1_own <= w_grant;
            r_s2_own <= r_s1_own;
            r_ram_we <= (w_grant == OWN_CPU_WR);

            if (w_cpu_grant) begin
                r_ram_addr <= bus.cpu_addr;
                r_ram_din  <= bus.cpu_din;
            end else if (w_vid_grant) begin
                r_ram_addr <= bus.vid_addr;
            end

            // RAM sampled the address one edge ago; its output is valid now.
            r_cpu_ack   <= (r_s2_own == OWN_CPU_RD) || (r_s2_own == OWN_CPU_WR);
            r_vid_valid <= (r_s2_own == OWN_VID);
            if (r_s2_own == OWN_CPU_RD) begin
                r_cpu_dout <= bus.ram_dout;
            end
            if (r_s2_own == OWN_VID) begin
                r_vid_dout <= bus.ram_dout;
            end
        end
    end

    // Busy drops on the edge that sees the completion pulse high, so a requester still
    // holding req from the finished access cannot be granted a second time.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_busy <= 1'b0;
            r_vid_busy <= 1'b0;
        end else begin
            if (w_cpu_grant) begin
                r_cpu_busy <= 1'b1;
            end else if (r_cpu_ack) begin
                r_cpu_busy <= 1'b0;
            end

            if (w_vid_grant) begin
                r_vid_busy <= 1'b1;
            end else if (r_vid_valid) begin
                r_vid_busy <= 1'b0;
            end
        end
    end

    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_din   = r_ram_din;
    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.cpu_dout  = r_cpu_dout;
    assign bus.vid_valid = r_vid_valid;
    assign bus.vid_dout  = r_vid_dout;

endmodule

// File: tb/tb_vball_vram_arbiter.sv
// Self-checking bench for vball_vram_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-indexed reference model of the arbitration rules.
module tb_vball_vram_arbiter;

    localparam int AW       = 13;
    localparam int DW       = 8;
    localparam int DEPTH    = 1 << AW;
    localparam int MAX_WAIT = 6;

    logic clk = 1'b0;
    logic reset;
    logic hb;
    logic vb;

    vball_vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    vball_vram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .i_hb  (hb),
        .i_vb  (vb),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Initial RAM content is a fixed address pattern; storage holds value XOR pattern.
    function automatic logic [7:0] init_pat(input logic [12:0] a);
        return a[7:0] ^ {3'b000, a[12:8]} ^ 8'h78;
    endfunction

    bit [7:0] ram_mem [DEPTH];

    always @(posedge clk) begin
        if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din ^ init_pat(bus.ram_addr);
        bus.ram_dout <= ram_mem[bus.ram_addr] ^ init_pat(bus.ram_addr);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int       due;
        bit       is_cpu;
        bit       is_wr;
        bit [7:0] data;
    } done_t;

    done_t     pend[$];
    bit [7:0]  ref_mem [DEPTH];
    int        edge_n = 0;
    int        cpu_free_at = 0;
    int        vid_free_at = 0;
    int        m_wait = 0;
    bit [12:0] m_addr = '0;
    bit        m_we = 1'b0;
    bit [7:0]  m_din = '0;
    bit [7:0]  m_cpu_dout = '0;
    bit [7:0]  m_vid_dout = '0;
    bit        cpu_grant_seen = 1'b0;

    // Predicts the effect of the upcoming edge from the inputs currently driven.
    task automatic model_step();
        int n;
        bit cpu_el, vid_el, force_cpu, cpu_wins, vid_wins;
        n = edge_n + 1;
        if (reset) begin
            pend.delete();
            cpu_free_at = 0; vid_free_at = 0; m_wait = 0;
            m_addr = '0; m_we = 1'b0; m_din = '0;
            m_cpu_dout = '0; m_vid_dout = '0;
            cpu_grant_seen = 1'b0;
            return;
        end
        cpu_el = bus.cpu_req && (n >= cpu_free_at);
        vid_el = bus.vid_req && (n >= vid_free_at);
`ifdef VBALL_VRAM_GUARD_EN
        force_cpu = (m_wait >= MAX_WAIT);
`else
        force_cpu = 1'b0;
`endif
        if (!cpu_el)           cpu_wins = 1'b0;
        else if (force_cpu)    cpu_wins = 1'b1;
        else if (!hb && !vb)   cpu_wins = !vid_el;
        else                   cpu_wins = 1'b1;
        vid_wins = vid_el && !cpu_wins;

        m_we = 1'b0;
        if (cpu_wins) begin
            // Completion pulse at n+2, seen by the arbiter at n+3, free again at n+4.
            cpu_free_at = n + 4;
            cpu_grant_seen = 1'b1;
            m_addr = bus.cpu_addr;
            if (bus.cpu_we) begin
                m_we = 1'b1;
                m_din = bus.cpu_din;
                ref_mem[bus.cpu_addr] = bus.cpu_din;
                pend.push_back('{due: n + 2, is_cpu: 1'b1, is_wr: 1'b1, data: 8'h00});
            end else begin
                pend.push_back('{due: n + 2, is_cpu: 1'b1, is_wr: 1'b0, data: ref_mem[bus.cpu_addr]});
            end
        end else if (vid_wins) begin
            vid_free_at = n + 4;
            m_addr = bus.vid_addr;
            pend.push_back('{due: n + 2, is_cpu: 1'b0, is_wr: 1'b0, data: ref_mem[bus.vid_addr]});
        end

        if (!bus.cpu_req || cpu_wins) m_wait = 0;
        else if (cpu_el && m_wait < 15) m_wait++;
    endtask

    task automatic check_outputs();
        bit exp_cack, exp_vval;
        exp_cack = 1'b0;
        exp_vval = 1'b0;
        while (pend.size() > 0 && pend[0].due <= edge_n) begin
            done_t d;
            d = pend.pop_front();
            if (d.is_cpu) begin
                exp_cack = 1'b1;
                if (!d.is_wr) m_cpu_dout = d.data;
            end else begin
                exp_vval = 1'b1;
                m_vid_dout = d.data;
            end
        end
        check("ram_we",    32'(bus.ram_we),    32'(m_we));
        check("ram_addr",  32'(bus.ram_addr),  32'(m_addr));
        if (m_we) check("ram_din", 32'(bus.ram_din), 32'(m_din));
        check("cpu_ack",   32'(bus.cpu_ack),   32'(exp_cack));
        check("vid_valid", 32'(bus.vid_valid), 32'(exp_vval));
        check("cpu_dout",  32'(bus.cpu_dout),  32'(m_cpu_dout));
        check("vid_dout",  32'(bus.vid_dout),  32'(m_vid_dout));
    endtask

    // One clock edge: predict, advance, sample #1 after the edge, compare.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        edge_n++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_cpu_ack(output int lat);
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (bus.cpu_ack) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            tick();
            if (bus.cpu_ack)   bus.cpu_req = 1'b0;
            if (bus.vid_valid) bus.vid_req = 1'b0;
            done = !bus.cpu_req && !bus.vid_req && (pend.size() == 0);
        end
        check("drain_done", 32'(done), 32'd1);
    endtask

    // ---------------- random requester agents ----------------
    bit cpu_out = 1'b0;
    bit vid_out = 1'b0;

    task automatic agent_cpu();
        if (bus.cpu_ack) begin
            cpu_out = 1'b0;
            bus.cpu_req = 1'b0;
        end else if (cpu_out && bus.cpu_req && cpu_grant_seen && $urandom_range(7) == 0) begin
            bus.cpu_req = 1'b0;
        end
        if (!cpu_out && $urandom_range(2) != 0) begin
            cpu_out = 1'b1;
            cpu_grant_seen = 1'b0;
            bus.cpu_req  = 1'b1;
            bus.cpu_we   = 1'($urandom_range(1));
            bus.cpu_addr = ($urandom_range(1) == 0) ? 13'($urandom_range(15)) : 13'($urandom);
            bus.cpu_din  = 8'($urandom);
        end
    endtask

    task automatic agent_vid();
        if (bus.vid_valid) begin
            vid_out = 1'b0;
            bus.vid_req = 1'b0;
        end
        if (!vid_out && $urandom_range(3) != 0) begin
            vid_out = 1'b1;
            bus.vid_req  = 1'b1;
            bus.vid_addr = ($urandom_range(1) == 0) ? 13'($urandom_range(15)) : 13'($urandom);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, cnt, we_seen, raise_e, gedge;
        bit granted;

        for (int a = 0; a < DEPTH; a++) ref_mem[a] = init_pat(13'(a));

        reset = 1'b1; hb = 1'b0; vb = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
        bus.vid_req = 1'b0; bus.vid_addr = '0;

        // Reset then idle: outputs stay 0, no write strobe.
        idle(3);
        reset = 1'b0;
        we_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            we_seen += int'(bus.ram_we);
        end
        check("idle_no_we", 32'(we_seen), 32'd0);

        // Blanking CPU read of 0x0123.
        hb = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0123;
        tick();
        check("t2_grant_addr", 32'(bus.ram_addr), 32'h0123);
        wait_cpu_ack(lat);
        bus.cpu_req = 1'b0;
        check("t2_latency", 32'(lat), 32'd2);
        check("t2_dout", 32'(bus.cpu_dout), 32'h5A);
        idle(2);

        // Display: video and CPU write together; video first, CPU next edge.
        hb = 1'b0; vb = 1'b0;
        bus.vid_req = 1'b1; bus.vid_addr = 13'h0456;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h1FFF; bus.cpu_din = 8'hA5;
        tick();
        check("t3_vid_first_addr", 32'(bus.ram_addr), 32'h0456);
        check("t3_vid_first_we", 32'(bus.ram_we), 32'd0);
        tick();
        check("t3_cpu_we", 32'(bus.ram_we), 32'd1);
        check("t3_cpu_addr", 32'(bus.ram_addr), 32'h1FFF);
        check("t3_cpu_din", 32'(bus.ram_din), 32'hA5);
        tick();
        check("t3_vid_valid", 32'(bus.vid_valid), 32'd1);
        check("t3_cpu_ack_early", 32'(bus.cpu_ack), 32'd0);
        check("t3_we_one_cycle", 32'(bus.ram_we), 32'd0);
        bus.vid_req = 1'b0;
        tick();
        check("t3_cpu_ack", 32'(bus.cpu_ack), 32'd1);
        check("t3_vid_valid_once", 32'(bus.vid_valid), 32'd0);
        bus.cpu_req = 1'b0;
        idle(2);

        // Display: fetcher reissues continuously, CPU write held.
        bus.vid_req = 1'b1; bus.vid_addr = 13'h0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.vid_valid) bus.vid_addr = bus.vid_addr + 13'd1;
        end
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h0AAA; bus.cpu_din = 8'h3C;
        raise_e = edge_n + 1;
        granted = 1'b0;
        gedge = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.vid_valid) bus.vid_addr = bus.vid_addr + 13'd1;
            if (bus.ram_we && !granted) begin
                granted = 1'b1;
                gedge = edge_n;
            end
            if (bus.cpu_ack) begin
                bus.cpu_req = 1'b0;
                break;
            end
        end
        check("t4_cpu_granted", 32'(granted), 32'd1);
`ifdef VBALL_VRAM_GUARD_EN
        check("t4_guard_bound", 32'((gedge - raise_e) <= 7), 32'd1);
`endif
        drain();

        // Reset one cycle after a CPU read grant: no ack, then a clean reissue.
        hb = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0321;
        tick();
        check("t5_grant_addr", 32'(bus.ram_addr), 32'h0321);
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        tick();
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            cnt += int'(bus.cpu_ack);
        end
        check("t5_ack_suppressed", 32'(cnt), 32'd0);
        bus.cpu_req = 1'b1;
        tick();
        wait_cpu_ack(lat);
        bus.cpu_req = 1'b0;
        check("t5_reissue_latency", 32'(lat), 32'd2);
        check("t5_reissue_dout", 32'(bus.cpu_dout), 32'(init_pat(13'h0321)));
        idle(2);

        // hb rises at the decision edge with both requesters eligible.
        hb = 1'b0; vb = 1'b0;
        idle(1);
        hb = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0777;
        bus.vid_req = 1'b1; bus.vid_addr = 13'h0888;
        tick();
        check("t6_cpu_first", 32'(bus.ram_addr), 32'h0777);
        drain();
        idle(2);

        // Randomized traffic with blanking changes and occasional reset.
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (reset) begin
                reset = 1'b0;
                cpu_out = 1'b0; vid_out = 1'b0;
                bus.cpu_req = 1'b0; bus.vid_req = 1'b0;
            end else begin
                agent_cpu();
                agent_vid();
            end
            if ($urandom_range(7) == 0)  hb = ~hb;
            if ($urandom_range(63) == 0) vb = ~vb;
            if ($urandom_range(399) == 0) reset = 1'b1;
        end
        reset = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
